// File: rtl/mem_port_arbiter.sv
// Two-client acquire arbiter with burst locking and per-client
// outstanding-transaction limits; grants are routed back by xact_id[2].
module mem_port_arbiter #(
    parameter int NBEATS    = 4,
    parameter int MAX_OUTST = 4
) (
    input  logic         clk,
    input  logic         reset,

    input  logic         c0_acq_valid,
    output logic         c0_acq_ready,
    input  logic [25:0]  c0_acq_addr_block,
    input  logic [1:0]   c0_acq_xact_id,
    input  logic [1:0]   c0_acq_addr_beat,
    input  logic         c0_acq_builtin,
    input  logic [2:0]   c0_acq_a_type,
    input  logic         c0_acq_has_data,
    input  logic [127:0] c0_acq_data,

    input  logic         c1_acq_valid,
    output logic         c1_acq_ready,
    input  logic [25:0]  c1_acq_addr_block,
    input  logic [1:0]   c1_acq_xact_id,
    input  logic [1:0]   c1_acq_addr_beat,
    input  logic         c1_acq_builtin,
    input  logic [2:0]   c1_acq_a_type,
    input  logic         c1_acq_has_data,
    input  logic [127:0] c1_acq_data,

    output logic         mem_acq_valid,
    input  logic         mem_acq_ready,
    output logic [25:0]  mem_acq_addr_block,
    output logic [2:0]   mem_acq_xact_id,
    output logic [1:0]   mem_acq_addr_beat,
    output logic         mem_acq_builtin,
    output logic [2:0]   mem_acq_a_type,
    output logic         mem_acq_has_data,
    output logic [127:0] mem_acq_data,

    input  logic         mem_gnt_valid,
    output logic         mem_gnt_ready,
    input  logic [2:0]   mem_gnt_xact_id,
    input  logic [1:0]   mem_gnt_addr_beat,
    input  logic [3:0]   mem_gnt_g_type,
    input  logic         mem_gnt_has_data,
    input  logic [127:0] mem_gnt_data,

    output logic         c0_gnt_valid,
    input  logic         c0_gnt_ready,
    output logic [1:0]   c0_gnt_xact_id,
    output logic [1:0]   c0_gnt_addr_beat,
    output logic [3:0]   c0_gnt_g_type,
    output logic [127:0] c0_gnt_data,

    output logic         c1_gnt_valid,
    input  logic         c1_gnt_ready,
    output logic [1:0]   c1_gnt_xact_id,
    output logic [1:0]   c1_gnt_addr_beat,
    output logic [3:0]   c1_gnt_g_type,
    output logic [127:0] c1_gnt_data,

    output logic [2:0]   c0_outst,
    output logic [2:0]   c1_outst
);

    localparam logic [1:0] LAST_BEAT = 2'(NBEATS - 1);
    localparam logic [2:0] MAX_O     = 3'(MAX_OUTST);

    typedef enum logic [1:0] {
        IDLE,
        LOCK0,
        LOCK1
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] beat_q, beat_d;
    logic       rr_last_q, rr_last_d;
    logic       hold_q, hold_d;
    logic       hold_sel_q, hold_sel_d;
    logic [2:0] c0_outst_q, c0_outst_d;
    logic [2:0] c1_outst_q, c1_outst_d;

    logic locked, lock_id;
    logic elig0, elig1, cand0, cand1;
    logic sel, sel_act, sel_valid, sel_has_data;
    logic acq_hs, first_hs, final_hs;
    logic gnt_dest, gnt_hs, gnt_last;

    function automatic logic [2:0] next_cnt(
        input logic [2:0] cnt,
        input logic       inc,
        input logic       dec
    );
        logic [2:0] res;
        res = cnt;
        if (inc && !dec) begin
            res = cnt + 3'd1;
        end else if (dec && !inc && cnt != 3'd0) begin
            res = cnt - 3'd1;
        end
        return res;
    endfunction

    // Client selection: a lock or a stalled offer pins the choice
    always_comb begin
        locked  = (state_q != IDLE);
        lock_id = (state_q == LOCK1);
        elig0   = (c0_outst_q < MAX_O) || (state_q == LOCK0);
        elig1   = (c1_outst_q < MAX_O) || (state_q == LOCK1);
        cand0   = c0_acq_valid && elig0;
        cand1   = c1_acq_valid && elig1;
        sel     = 1'b0;
        sel_act = 1'b0;
        if (locked) begin
            sel     = lock_id;
            sel_act = 1'b1;
        end else if (hold_q) begin
            sel     = hold_sel_q;
            sel_act = 1'b1;
        end else if (cand0 && cand1) begin
            sel     = ~rr_last_q;
            sel_act = 1'b1;
        end else if (cand1) begin
            sel     = 1'b1;
            sel_act = 1'b1;
        end else begin
            sel     = 1'b0;
            sel_act = cand0;
        end
    end

    always_comb begin
        sel_valid    = sel ? c1_acq_valid : c0_acq_valid;
        sel_has_data = sel ? c1_acq_has_data : c0_acq_has_data;

        mem_acq_valid      = !reset && sel_act && sel_valid;
        mem_acq_addr_block = sel ? c1_acq_addr_block : c0_acq_addr_block;
        mem_acq_xact_id    = {sel, sel ? c1_acq_xact_id : c0_acq_xact_id};
        mem_acq_addr_beat  = sel ? c1_acq_addr_beat : c0_acq_addr_beat;
        mem_acq_builtin    = sel ? c1_acq_builtin : c0_acq_builtin;
        mem_acq_a_type     = sel ? c1_acq_a_type : c0_acq_a_type;
        mem_acq_has_data   = sel_has_data;
        mem_acq_data       = sel ? c1_acq_data : c0_acq_data;

        c0_acq_ready = !reset && sel_act && !sel
                       && mem_acq_ready && elig0;
        c1_acq_ready = !reset && sel_act && sel
                       && mem_acq_ready && elig1;

        acq_hs   = mem_acq_valid && mem_acq_ready;
        first_hs = acq_hs && !locked;
        final_hs = acq_hs && (locked ? (beat_q == LAST_BEAT)
                                     : !sel_has_data);
    end

    always_comb begin
        gnt_dest      = mem_gnt_xact_id[2];
        mem_gnt_ready = !reset
                        && (gnt_dest ? c1_gnt_ready : c0_gnt_ready);
        c0_gnt_valid  = !reset && mem_gnt_valid && !gnt_dest;
        c1_gnt_valid  = !reset && mem_gnt_valid && gnt_dest;

        c0_gnt_xact_id   = mem_gnt_xact_id[1:0];
        c0_gnt_addr_beat = mem_gnt_addr_beat;
        c0_gnt_g_type    = mem_gnt_g_type;
        c0_gnt_data      = mem_gnt_data;
        c1_gnt_xact_id   = mem_gnt_xact_id[1:0];
        c1_gnt_addr_beat = mem_gnt_addr_beat;
        c1_gnt_g_type    = mem_gnt_g_type;
        c1_gnt_data      = mem_gnt_data;

        gnt_hs   = mem_gnt_valid && mem_gnt_ready;
        gnt_last = gnt_hs && (!mem_gnt_has_data
                              || mem_gnt_addr_beat == LAST_BEAT);
    end

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        rr_last_d  = rr_last_q;
        hold_d     = mem_acq_valid && !mem_acq_ready && !locked;
        hold_sel_d = sel;

        if (acq_hs) begin
            if (!locked) begin
                if (sel_has_data) begin
                    state_d = sel ? LOCK1 : LOCK0;
                    beat_d  = beat_q + 2'd1;
                end
            end else if (beat_q == LAST_BEAT) begin
                state_d = IDLE;
                beat_d  = 2'd0;
            end else begin
                beat_d = beat_q + 2'd1;
            end
        end

        if (final_hs) begin
            rr_last_d = sel;
        end

        c0_outst_d = next_cnt(c0_outst_q,
                              first_hs && !sel,
                              gnt_last && !gnt_dest);
        c1_outst_d = next_cnt(c1_outst_q,
                              first_hs && sel,
                              gnt_last && gnt_dest);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            beat_q     <= 2'd0;
            rr_last_q  <= 1'b1;
            hold_q     <= 1'b0;
            hold_sel_q <= 1'b0;
            c0_outst_q <= 3'd0;
            c1_outst_q <= 3'd0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            rr_last_q  <= rr_last_d;
            hold_q     <= hold_d;
            hold_sel_q <= hold_sel_d;
            c0_outst_q <= c0_outst_d;
            c1_outst_q <= c1_outst_d;
        end
    end

    assign c0_outst = c0_outst_q;
    assign c1_outst = c1_outst_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: an abstract per-cycle model
// plus literal expectations for the key arbitration scenarios.
module tb_mem_port_arbiter;

    localparam int NB = 4;
    localparam int MO = 4;

    logic         clk, reset;
    logic         c0_acq_valid, c0_acq_ready;
    logic [25:0]  c0_acq_addr_block;
    logic [1:0]   c0_acq_xact_id, c0_acq_addr_beat;
    logic         c0_acq_builtin;
    logic [2:0]   c0_acq_a_type;
    logic         c0_acq_has_data;
    logic [127:0] c0_acq_data;
    logic         c1_acq_valid, c1_acq_ready;
    logic [25:0]  c1_acq_addr_block;
    logic [1:0]   c1_acq_xact_id, c1_acq_addr_beat;
    logic         c1_acq_builtin;
    logic [2:0]   c1_acq_a_type;
    logic         c1_acq_has_data;
    logic [127:0] c1_acq_data;
    logic         mem_acq_valid, mem_acq_ready;
    logic [25:0]  mem_acq_addr_block;
    logic [2:0]   mem_acq_xact_id;
    logic [1:0]   mem_acq_addr_beat;
    logic         mem_acq_builtin;
    logic [2:0]   mem_acq_a_type;
    logic         mem_acq_has_data;
    logic [127:0] mem_acq_data;
    logic         mem_gnt_valid, mem_gnt_ready;
    logic [2:0]   mem_gnt_xact_id;
    logic [1:0]   mem_gnt_addr_beat;
    logic [3:0]   mem_gnt_g_type;
    logic         mem_gnt_has_data;
    logic [127:0] mem_gnt_data;
    logic         c0_gnt_valid, c0_gnt_ready;
    logic [1:0]   c0_gnt_xact_id, c0_gnt_addr_beat;
    logic [3:0]   c0_gnt_g_type;
    logic [127:0] c0_gnt_data;
    logic         c1_gnt_valid, c1_gnt_ready;
    logic [1:0]   c1_gnt_xact_id, c1_gnt_addr_beat;
    logic [3:0]   c1_gnt_g_type;
    logic [127:0] c1_gnt_data;
    logic [2:0]   c0_outst, c1_outst;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.NBEATS(NB), .MAX_OUTST(MO)) dut (
        .clk(clk), .reset(reset),
        .c0_acq_valid(c0_acq_valid), .c0_acq_ready(c0_acq_ready),
        .c0_acq_addr_block(c0_acq_addr_block),
        .c0_acq_xact_id(c0_acq_xact_id),
        .c0_acq_addr_beat(c0_acq_addr_beat),
        .c0_acq_builtin(c0_acq_builtin),
        .c0_acq_a_type(c0_acq_a_type),
        .c0_acq_has_data(c0_acq_has_data),
        .c0_acq_data(c0_acq_data),
        .c1_acq_valid(c1_acq_valid), .c1_acq_ready(c1_acq_ready),
        .c1_acq_addr_block(c1_acq_addr_block),
        .c1_acq_xact_id(c1_acq_xact_id),
        .c1_acq_addr_beat(c1_acq_addr_beat),
        .c1_acq_builtin(c1_acq_builtin),
        .c1_acq_a_type(c1_acq_a_type),
        .c1_acq_has_data(c1_acq_has_data),
        .c1_acq_data(c1_acq_data),
        .mem_acq_valid(mem_acq_valid), .mem_acq_ready(mem_acq_ready),
        .mem_acq_addr_block(mem_acq_addr_block),
        .mem_acq_xact_id(mem_acq_xact_id),
        .mem_acq_addr_beat(mem_acq_addr_beat),
        .mem_acq_builtin(mem_acq_builtin),
        .mem_acq_a_type(mem_acq_a_type),
        .mem_acq_has_data(mem_acq_has_data),
        .mem_acq_data(mem_acq_data),
        .mem_gnt_valid(mem_gnt_valid), .mem_gnt_ready(mem_gnt_ready),
        .mem_gnt_xact_id(mem_gnt_xact_id),
        .mem_gnt_addr_beat(mem_gnt_addr_beat),
        .mem_gnt_g_type(mem_gnt_g_type),
        .mem_gnt_has_data(mem_gnt_has_data),
        .mem_gnt_data(mem_gnt_data),
        .c0_gnt_valid(c0_gnt_valid), .c0_gnt_ready(c0_gnt_ready),
        .c0_gnt_xact_id(c0_gnt_xact_id),
        .c0_gnt_addr_beat(c0_gnt_addr_beat),
        .c0_gnt_g_type(c0_gnt_g_type), .c0_gnt_data(c0_gnt_data),
        .c1_gnt_valid(c1_gnt_valid), .c1_gnt_ready(c1_gnt_ready),
        .c1_gnt_xact_id(c1_gnt_xact_id),
        .c1_gnt_addr_beat(c1_gnt_addr_beat),
        .c1_gnt_g_type(c1_gnt_g_type), .c1_gnt_data(c1_gnt_data),
        .c0_outst(c0_outst), .c1_outst(c1_outst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Abstract model: who owns the port, how far a burst has got,
    // who went last, and how many requests each client has in flight.
    int m_lock = -1;
    int m_beat = 0;
    int m_rr   = 1;
    int m_pend = -1;
    int m_out [2] = '{0, 0};

    always @(negedge clk) begin
        bit           v [2], hd [2], e [2], inc [2], dec [2];
        logic [1:0]   xid [2], bt [2];
        logic [127:0] dat [2];
        int           s;
        bit           act, ev, hs, dst, glast, gr;
        if (reset) begin
            chk("rst_c0_acq_ready", 128'(c0_acq_ready), 128'(0));
            chk("rst_c1_acq_ready", 128'(c1_acq_ready), 128'(0));
            chk("rst_mem_acq_valid", 128'(mem_acq_valid), 128'(0));
            chk("rst_mem_gnt_ready", 128'(mem_gnt_ready), 128'(0));
            chk("rst_c0_gnt_valid", 128'(c0_gnt_valid), 128'(0));
            chk("rst_c1_gnt_valid", 128'(c1_gnt_valid), 128'(0));
            m_lock = -1; m_beat = 0; m_rr = 1; m_pend = -1;
            m_out[0] = 0; m_out[1] = 0;
        end else begin
            v[0] = c0_acq_valid;    v[1] = c1_acq_valid;
            hd[0] = c0_acq_has_data; hd[1] = c1_acq_has_data;
            xid[0] = c0_acq_xact_id; xid[1] = c1_acq_xact_id;
            bt[0] = c0_acq_addr_beat; bt[1] = c1_acq_addr_beat;
            dat[0] = c0_acq_data;   dat[1] = c1_acq_data;
            for (int n = 0; n < 2; n++)
                e[n] = (m_out[n] < MO) || (m_lock == n);
            if (m_lock >= 0) begin
                s = m_lock; act = 1;
            end else if (m_pend >= 0) begin
                s = m_pend; act = 1;
            end else begin
                bool_pick(v[0] && e[0], v[1] && e[1], s, act);
            end
            ev = act && v[s];
            chk("mdl_mem_acq_valid", 128'(mem_acq_valid), 128'(ev));
            chk("mdl_c0_acq_ready", 128'(c0_acq_ready),
                128'(act && s == 0 && mem_acq_ready && e[0]));
            chk("mdl_c1_acq_ready", 128'(c1_acq_ready),
                128'(act && s == 1 && mem_acq_ready && e[1]));
            if (ev) begin
                chk("mdl_acq_xact_id", 128'(mem_acq_xact_id),
                    128'({s[0], xid[s]}));
                chk("mdl_acq_beat", 128'(mem_acq_addr_beat),
                    128'(bt[s]));
                chk("mdl_acq_has_data", 128'(mem_acq_has_data),
                    128'(hd[s]));
                chk("mdl_acq_data", mem_acq_data, dat[s]);
            end
            chk("mdl_c0_outst", 128'(c0_outst), 128'(m_out[0]));
            chk("mdl_c1_outst", 128'(c1_outst), 128'(m_out[1]));

            dst = mem_gnt_xact_id[2];
            gr  = dst ? c1_gnt_ready : c0_gnt_ready;
            chk("mdl_mem_gnt_ready", 128'(mem_gnt_ready), 128'(gr));
            chk("mdl_c0_gnt_valid", 128'(c0_gnt_valid),
                128'(mem_gnt_valid && !dst));
            chk("mdl_c1_gnt_valid", 128'(c1_gnt_valid),
                128'(mem_gnt_valid && dst));
            if (mem_gnt_valid) begin
                chk("mdl_gnt_xid",
                    128'(dst ? c1_gnt_xact_id : c0_gnt_xact_id),
                    128'(mem_gnt_xact_id[1:0]));
                chk("mdl_gnt_data", dst ? c1_gnt_data : c0_gnt_data,
                    mem_gnt_data);
            end

            hs = ev && mem_acq_ready;
            glast = mem_gnt_valid && gr && (!mem_gnt_has_data
                    || int'(mem_gnt_addr_beat) == NB - 1);
            for (int n = 0; n < 2; n++) begin
                inc[n] = hs && m_lock < 0 && s == n;
                dec[n] = glast && int'(dst) == n;
            end
            m_pend = (ev && !mem_acq_ready && m_lock < 0) ? s : -1;
            if (hs) begin
                if (m_lock < 0) begin
                    if (hd[s]) begin
                        m_lock = s; m_beat = 1;
                    end else begin
                        m_rr = s;
                    end
                end else if (m_beat == NB - 1) begin
                    m_lock = -1; m_beat = 0; m_rr = s;
                end else begin
                    m_beat++;
                end
            end
            for (int n = 0; n < 2; n++) begin
                if (inc[n] && !dec[n]) m_out[n]++;
                else if (dec[n] && !inc[n] && m_out[n] > 0) m_out[n]--;
            end
        end
    end

    task automatic bool_pick(input bit a0, input bit a1,
                             output int s, output bit act);
        act = a0 || a1;
        if (a0 && a1) s = 1 - m_rr;
        else if (a1) s = 1;
        else s = 0;
    endtask

    task automatic cli(input int n, input logic v, input logic hd,
                       input logic [1:0] xid, input logic [1:0] bt);
        if (n == 0) begin
            c0_acq_valid = v; c0_acq_has_data = hd;
            c0_acq_xact_id = xid; c0_acq_addr_beat = bt;
            c0_acq_addr_block = 26'h0AB00 + 26'(xid);
            c0_acq_builtin = hd; c0_acq_a_type = {1'b0, xid};
            c0_acq_data = {64'hC0C0_0000_0000_0000, 60'h0, xid, bt};
        end else begin
            c1_acq_valid = v; c1_acq_has_data = hd;
            c1_acq_xact_id = xid; c1_acq_addr_beat = bt;
            c1_acq_addr_block = 26'h1CD00 + 26'(xid);
            c1_acq_builtin = !hd; c1_acq_a_type = {1'b1, xid};
            c1_acq_data = {64'hC1C1_0000_0000_0000, 60'h0, xid, bt};
        end
    endtask

    task automatic gnt(input logic v, input logic [2:0] xid,
                       input logic [1:0] bt, input logic hd);
        mem_gnt_valid = v; mem_gnt_xact_id = xid;
        mem_gnt_addr_beat = bt; mem_gnt_has_data = hd;
        mem_gnt_g_type = {2'b01, bt};
        mem_gnt_data = {96'hD00D, 27'h0, xid, bt};
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        cli(0, 0, 0, 0, 0); cli(1, 0, 0, 0, 0);
        gnt(0, 0, 0, 0);
        mem_acq_ready = 1; c0_gnt_ready = 0; c1_gnt_ready = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        nxt(); nxt();
        reset = 0;
    endtask

    initial begin
        int b;
        reset = 1;
        idle_inputs();
        do_reset();
        smp();
        chk("rst_c0_outst", 128'(c0_outst), 128'(0));
        chk("rst_c1_outst", 128'(c1_outst), 128'(0));
        nxt();

        // Alternating round robin, client 0 first after reset
        cli(0, 1, 0, 0, 0); cli(1, 1, 0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            smp(); chk("rr_src", 128'(mem_acq_xact_id[2]), 128'(i % 2));
            nxt();
        end
        cli(0, 0, 0, 0, 0); cli(1, 0, 0, 0, 0);
        smp();
        chk("rr_c0_outst", 128'(c0_outst), 128'(2));
        chk("rr_c1_outst", 128'(c1_outst), 128'(2));
        nxt();
        c0_gnt_ready = 1; c1_gnt_ready = 1;
        for (int i = 0; i < 4; i++) begin
            gnt(1, (i % 2) ? 3'b100 : 3'b000, 0, 0);
            smp(); chk("drain_gnt_ready", 128'(mem_gnt_ready), 128'(1));
            nxt();
        end
        gnt(0, 0, 0, 0);
        smp();
        chk("drain_c0_outst", 128'(c0_outst), 128'(0));
        chk("drain_c1_outst", 128'(c1_outst), 128'(0));
        nxt();

        // c1 burst locks out c0
        do_reset();
        cli(0, 1, 0, 1, 0);
        smp(); chk("pre_c0_ready", 128'(c0_acq_ready), 128'(1)); nxt();
        cli(1, 1, 1, 2, 0);
        smp();
        chk("b0_src", 128'(mem_acq_xact_id[2]), 128'(1));
        chk("b0_c0_ready", 128'(c0_acq_ready), 128'(0));
        nxt();
        for (int i = 1; i < 4; i++) begin
            cli(1, 1, 1, 2, 2'(i));
            smp();
            chk("burst_src", 128'(mem_acq_xact_id[2]), 128'(1));
            chk("burst_beat", 128'(mem_acq_addr_beat), 128'(i));
            chk("burst_c0_ready", 128'(c0_acq_ready), 128'(0));
            nxt();
        end
        cli(1, 0, 0, 0, 0);
        smp(); chk("post_c0_ready", 128'(c0_acq_ready), 128'(1)); nxt();
        cli(0, 0, 0, 0, 0);
        smp();
        chk("burst_c0_outst", 128'(c0_outst), 128'(2));
        chk("burst_c1_outst", 128'(c1_outst), 128'(1));
        nxt();

        // Outstanding limit
        do_reset();
        cli(0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            smp(); chk("lim_c0_ready", 128'(c0_acq_ready), 128'(1)); nxt();
        end
        smp();
        chk("lim_c0_outst", 128'(c0_outst), 128'(4));
        chk("lim_blocked", 128'(c0_acq_ready), 128'(0));
        chk("lim_no_valid", 128'(mem_acq_valid), 128'(0));
        nxt();
        c0_gnt_ready = 1; gnt(1, 3'b001, 0, 0);
        smp(); chk("lim_gnt_c0", 128'(c0_gnt_valid), 128'(1)); nxt();
        gnt(0, 0, 0, 0);
        smp();
        chk("lim_c0_outst3", 128'(c0_outst), 128'(3));
        chk("lim_reopen", 128'(c0_acq_ready), 128'(1));
        nxt();
        cli(0, 0, 0, 0, 0);
        smp(); chk("lim_c0_outst4", 128'(c0_outst), 128'(4)); nxt();

        // Same-cycle acquire and last grant for c0
        do_reset();
        cli(0, 1, 0, 1, 0);
        smp(); nxt();
        gnt(1, 3'b001, 0, 0); c0_gnt_ready = 1;
        smp();
        chk("same_acq", 128'(c0_acq_ready), 128'(1));
        chk("same_gnt", 128'(mem_gnt_ready), 128'(1));
        nxt();
        cli(0, 0, 0, 0, 0); gnt(0, 0, 0, 0);
        smp(); chk("same_outst", 128'(c0_outst), 128'(1)); nxt();

        // Grant burst to c1 with stuttering ready
        do_reset();
        cli(1, 1, 0, 3, 0);
        smp(); chk("g_c1_acq", 128'(c1_acq_ready), 128'(1)); nxt();
        cli(1, 0, 0, 0, 0);
        c0_gnt_ready = 1;
        b = 0;
        for (int k = 0; k < 12 && b < 4; k++) begin
            gnt(1, 3'b110, 2'(b), 1);
            c1_gnt_ready = k[0];
            smp();
            chk("g_c1_valid", 128'(c1_gnt_valid), 128'(1));
            chk("g_c0_valid", 128'(c0_gnt_valid), 128'(0));
            chk("g_c1_xid", 128'(c1_gnt_xact_id), 128'(2));
            chk("g_c1_beat", 128'(c1_gnt_addr_beat), 128'(b));
            if (c1_gnt_ready) b++;
            nxt();
        end
        gnt(0, 0, 0, 0);
        smp(); chk("g_c1_outst", 128'(c1_outst), 128'(0)); nxt();

        // Reset mid-burst
        do_reset();
        cli(0, 1, 1, 0, 0);
        smp(); chk("mr_b0", 128'(c0_acq_ready), 128'(1)); nxt();
        cli(0, 1, 1, 0, 1);
        smp(); chk("mr_b1", 128'(c0_acq_ready), 128'(1)); nxt();
        reset = 1; cli(1, 1, 0, 2, 0);
        gnt(1, 3'b100, 0, 0); c1_gnt_ready = 1;
        smp(); nxt();
        reset = 0; gnt(0, 0, 0, 0); cli(0, 0, 0, 0, 0);
        smp();
        chk("mr_c1_ready", 128'(c1_acq_ready), 128'(1));
        chk("mr_src", 128'(mem_acq_xact_id[2]), 128'(1));
        chk("mr_c0_outst", 128'(c0_outst), 128'(0));
        chk("mr_c1_outst", 128'(c1_outst), 128'(0));
        nxt();
        cli(1, 0, 0, 0, 0);
        smp(); chk("mr_c1_outst1", 128'(c1_outst), 128'(1)); nxt();

        // A stalled offer keeps its client even when the other arrives
        do_reset();
        mem_acq_ready = 0;
        cli(1, 1, 0, 1, 0);
        smp();
        chk("st_valid", 128'(mem_acq_valid), 128'(1));
        chk("st_src", 128'(mem_acq_xact_id[2]), 128'(1));
        nxt();
        cli(0, 1, 0, 0, 0);
        smp(); chk("st_src_held", 128'(mem_acq_xact_id[2]), 128'(1)); nxt();
        mem_acq_ready = 1;
        smp();
        chk("st_c1_go", 128'(c1_acq_ready), 128'(1));
        chk("st_c0_wait", 128'(c0_acq_ready), 128'(0));
        nxt();
        cli(1, 0, 0, 0, 0);
        smp(); chk("st_c0_go", 128'(c0_acq_ready), 128'(1)); nxt();
        idle_inputs();
        nxt();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: NBEATS, 4, beats per block (128-bit beats, 2-bit beat index).
REQ-002 Parameter: MAX_OUTST, 4, max outstanding transactions per client (1..7).
REQ-003 Clock/reset: reset reset, synchronous, active-high; clock clk.
REQ-004 clk  in  1  clock.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 cN_acq_valid/cN_acq_ready (N=0,1)  in/out  1  client acquire handshake.
REQ-007 cN_acq_addr_block  in  26  block address.
REQ-008 cN_acq_xact_id  in  2  client transaction id.
REQ-009 cN_acq_addr_beat  in  2  beat index.
REQ-010 cN_acq_builtin  in  1  is_builtin_type.
REQ-011 cN_acq_a_type  in  3  acquire type.
REQ-012 cN_acq_has_data  in  1  multi-beat data-carrying acquire.
REQ-013 cN_acq_data  in  128  beat data.
REQ-014 mem_acq_valid/mem_acq_ready  out/in  1  memory acquire handshake.
REQ-015 mem_acq_{addr_block,addr_beat,builtin,a_type,has_data,data}  out  26/2/1/3/1/128  forwarded fields.
REQ-016 mem_acq_xact_id  out  3  {source client, client xact_id}.
REQ-017 mem_gnt_valid/mem_gnt_ready  in/out  1  memory grant handshake.
REQ-018 mem_gnt_{xact_id,addr_beat,g_type,has_data,data}  in  3/2/4/1/128  grant fields.
REQ-019 cN_gnt_valid/cN_gnt_ready  out/in  1  client grant handshake.
REQ-020 cN_gnt_{xact_id,addr_beat,g_type,data}  out  2/2/4/128  routed grant fields.
REQ-021 cN_outst  out  3  current outstanding count.

Function
REQ-022 Acquire path combinational: zero-cycle latency from selected client to mem_acq_*; cN_acq_ready = selected(N) & mem_acq_ready & eligible(N).
REQ-023 eligible(N): cN_outst < MAX_OUTST, or arbiter locked to N mid-burst.
REQ-024 States: IDLE (unlocked) and LOCK0/LOCK1 (burst in progress for client 0/1).
REQ-025 IDLE: round-robin among valid eligible clients; priority to client not equal to rr_last; single requester always wins.
REQ-026 IDLE -> LOCKN on handshake of has_data=1 beat with beat counter 0; beat counter increments per handshake.
REQ-027 LOCKN -> IDLE on handshake of beat NBEATS-1; counter wraps to 0; other client's valid ignored while locked.
REQ-028 has_data=0 acquire is single beat; no lock.
REQ-029 rr_last updates to N on final-beat handshake only (single beat or beat NBEATS-1).
REQ-030 cN_outst increments on first-beat handshake of N; decrements on last grant beat handshake for N; both same cycle -> unchanged.
REQ-031 Last grant beat: mem_gnt_has_data=0, or addr_beat = NBEATS-1.
REQ-032 Grant routing combinational: dest = mem_gnt_xact_id[2]; c(dest)_gnt_valid = mem_gnt_valid; other gnt_valid = 0; mem_gnt_ready = c(dest)_gnt_ready; xact_id[1:0], beat, g_type, data passed through.
REQ-033 Decrement at cN_outst=0 is a protocol error: count held at 0.
REQ-034 mem_acq_valid held stable with fields until mem_acq_ready; arbiter never switches client while mem_acq_valid=1 and not accepted.

Reset
REQ-035 Reset: state IDLE, beat counter 0, rr_last=1 (client 0 wins first tie), cN_outst=0.
REQ-036 During reset all cN_acq_ready, cN_gnt_valid, mem_acq_valid, mem_gnt_ready = 0.
REQ-037 Reset mid-burst abandons lock and counts; no partial state survives.

Verification
REQ-038 Both clients valid single-beat after reset -> c0 granted cycle 1, c1 cycle 2, alternating; mem_acq_xact_id[2] = 0,1,0,1.
REQ-039 c1 has_data burst beats 0..3, c0 valid throughout -> four consecutive c1 beats, c0 accepted only after beat 3.
REQ-040 c0 issues 4 acquires, no grants -> c0_outst=4, c0_acq_ready=0; one last-beat grant xact_id=3'b0xx -> c0_outst=3, next acquire accepted.
REQ-041 mem_gnt xact_id=3'b110, 4 data beats, c1_gnt_ready toggling -> c1 receives beats 0..3 with xact_id 2'b10; c0_gnt_valid stays 0.
REQ-042 Same-cycle c0 acquire handshake and c0 last-grant -> c0_outst unchanged.
REQ-043 Reset asserted after beat 1 of c0 burst -> IDLE, counts 0; c1 single-beat request next cycle after release accepted immediately.
